// File: rtl/fgyrus_band_agg.sv
// Per-frame band aggregator for the Fgyrus FFT result stream: bins are summed into
// linear bands, then folded into a peak-held level. Peak decay is enabled by FGYRUS_BAND_PEAK_HOLD_EN.
module fgyrus_band_agg #(
  parameter int P_DATA_W      = 32,
  parameter int P_BIN_ADDR_W  = 7,
  parameter int P_BAND_SHIFT  = 4,
  parameter int P_NUM_BANDS   = 8,
  parameter int P_BAND_IDX_W  = 3,
  parameter int P_DECAY_SHIFT = 3
) (
  input  logic                    clk_ir,
  input  logic                    rst_ih,
  input  logic [P_BIN_ADDR_W-1:0] fft_res_wr_addr_id,
  input  logic [P_DATA_W-1:0]     fft_res_wr_data_id,
  input  logic                    fft_res_wr_en_ih,
  input  logic                    fgyrus_fft_done_ih,
  input  logic                    band_rd_en_ih,
  input  logic [P_BAND_IDX_W-1:0] band_rd_idx_id,
  output logic                    band_rd_valid_oh,
  output logic [P_DATA_W-1:0]     band_rd_data_od,
  output logic                    band_rdy_oh,
  output logic                    busy_oh,
  input  logic                    ovr_clr_ih,
  output logic                    ovr_oh
);

  typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_UPDATE = 1'b1} state_t;

  function automatic logic [P_DATA_W-1:0] sat_add(input logic [P_DATA_W-1:0] a,
                                                  input logic [P_DATA_W-1:0] b);
    logic [P_DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[P_DATA_W] ? {P_DATA_W{1'b1}} : sum[P_DATA_W-1:0];
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [P_BAND_IDX_W-1:0] idx_r;
  logic [P_DATA_W-1:0]     acc_r    [P_NUM_BANDS];
  logic [P_DATA_W-1:0]     shadow_r [P_NUM_BANDS];
  logic [P_DATA_W-1:0]     band_r   [P_NUM_BANDS];
  logic [P_DATA_W-1:0]     acc_add_s[P_NUM_BANDS];
  logic [P_BIN_ADDR_W-1:0] wr_band_s;
  logic                    wr_hit_s;
  logic                    latch_s;
  logic                    last_s;
  logic [P_DATA_W-1:0]     band_new_s;
  logic                    band_rdy_r, ovr_r, rd_valid_r;
  logic [P_DATA_W-1:0]     rd_data_r;

  assign wr_band_s = fft_res_wr_addr_id >> P_BAND_SHIFT;
  assign wr_hit_s  = fft_res_wr_en_ih && (32'(wr_band_s) < P_NUM_BANDS);
  assign latch_s   = (state_r == ST_ACCUM) && fgyrus_fft_done_ih;
  assign last_s    = (idx_r == P_BAND_IDX_W'(P_NUM_BANDS - 1));

  // Saturating add of the incoming bin into its band accumulator.
  always_comb begin
    for (int b = 0; b < P_NUM_BANDS; b++) begin
      if (wr_hit_s && (wr_band_s == P_BIN_ADDR_W'(b))) begin
        acc_add_s[b] = sat_add(acc_r[b], fft_res_wr_data_id);
      end else begin
        acc_add_s[b] = acc_r[b];
      end
    end
  end

`ifdef FGYRUS_BAND_PEAK_HOLD_EN
  logic [P_DATA_W-1:0] cur_band_s, decayed_s;
  assign cur_band_s = band_r[idx_r];
  // Decay can never underflow since the subtrahend is a right shift of the minuend.
  assign decayed_s  = cur_band_s - (cur_band_s >> P_DECAY_SHIFT);
  assign band_new_s = (shadow_r[idx_r] > decayed_s) ? shadow_r[idx_r] : decayed_s;
`else
  assign band_new_s = shadow_r[idx_r];
`endif

  // Frame FSM state register.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: latch on frame done, sweep all bands once, return.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (fgyrus_fft_done_ih) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_UPDATE: begin
        if (last_s) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_UPDATE;
        end
      end
      default: state_nxt_s = ST_ACCUM;
    endcase
  end

  // Accumulators, frame shadow and band levels; accumulation continues during UPDATE.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      for (int b = 0; b < P_NUM_BANDS; b++) begin
        acc_r[b]    <= '0;
        shadow_r[b] <= '0;
        band_r[b]   <= '0;
      end
      idx_r <= '0;
    end else if (latch_s) begin
      for (int b = 0; b < P_NUM_BANDS; b++) begin
        shadow_r[b] <= acc_add_s[b];
        acc_r[b]    <= '0;
      end
      idx_r <= '0;
    end else begin
      for (int b = 0; b < P_NUM_BANDS; b++) begin
        acc_r[b] <= acc_add_s[b];
      end
      if (state_r == ST_UPDATE) begin
        band_r[idx_r] <= band_new_s;
        idx_r         <= last_s ? '0 : idx_r + 1'b1;
      end
    end
  end

  // Ready pulse, sticky overrun (set beats clear) and the registered read port.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      band_rdy_r <= 1'b0;
      ovr_r      <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      band_rdy_r <= (state_r == ST_UPDATE) && last_s;
      if ((state_r == ST_UPDATE) && fgyrus_fft_done_ih) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr_ih) begin
        ovr_r <= 1'b0;
      end
      rd_valid_r <= band_rd_en_ih;
      if (band_rd_en_ih) begin
        rd_data_r <= band_r[band_rd_idx_id];
      end
    end
  end

  assign band_rd_valid_oh = rd_valid_r;
  assign band_rd_data_od  = rd_data_r;
  assign band_rdy_oh      = band_rdy_r;
  assign busy_oh          = (state_r == ST_UPDATE);
  assign ovr_oh           = ovr_r;

endmodule

// File: tb/tb_fgyrus_band_agg.sv
// Directed self-checking bench for fgyrus_band_agg; expectations follow FGYRUS_BAND_PEAK_HOLD_EN.
module tb_fgyrus_band_agg;

  logic        clk_ir = 1'b0;
  logic        rst_ih = 1'b1;
  logic [6:0]  fft_res_wr_addr_id = '0;
  logic [31:0] fft_res_wr_data_id = '0;
  logic        fft_res_wr_en_ih = 1'b0;
  logic        fgyrus_fft_done_ih = 1'b0;
  logic        band_rd_en_ih = 1'b0;
  logic [2:0]  band_rd_idx_id = '0;
  logic        band_rd_valid_oh;
  logic [31:0] band_rd_data_od;
  logic        band_rdy_oh;
  logic        busy_oh;
  logic        ovr_clr_ih = 1'b0;
  logic        ovr_oh;

  int errors = 0;
  int checks = 0;

  fgyrus_band_agg dut (
    .clk_ir(clk_ir), .rst_ih(rst_ih),
    .fft_res_wr_addr_id(fft_res_wr_addr_id), .fft_res_wr_data_id(fft_res_wr_data_id),
    .fft_res_wr_en_ih(fft_res_wr_en_ih), .fgyrus_fft_done_ih(fgyrus_fft_done_ih),
    .band_rd_en_ih(band_rd_en_ih), .band_rd_idx_id(band_rd_idx_id),
    .band_rd_valid_oh(band_rd_valid_oh), .band_rd_data_od(band_rd_data_od),
    .band_rdy_oh(band_rdy_oh), .busy_oh(busy_oh),
    .ovr_clr_ih(ovr_clr_ih), .ovr_oh(ovr_oh)
  );

  always #5 clk_ir = ~clk_ir;

  task automatic cyc;
    @(posedge clk_ir);
    #1;
  endtask

  task automatic wr_bin(input int addr, input logic [31:0] data);
    fft_res_wr_addr_id = addr[6:0];
    fft_res_wr_data_id = data;
    fft_res_wr_en_ih   = 1'b1;
    cyc();
    fft_res_wr_en_ih   = 1'b0;
  endtask

  task automatic pulse_done;
    fgyrus_fft_done_ih = 1'b1;
    cyc();
    fgyrus_fft_done_ih = 1'b0;
  endtask

  task automatic read_band(input int i, input logic [31:0] exp, input string nm);
    band_rd_en_ih  = 1'b1;
    band_rd_idx_id = i[2:0];
    cyc();
    band_rd_en_ih  = 1'b0;
    checks++;
    if (band_rd_valid_oh !== 1'b1 || band_rd_data_od !== exp) begin
      errors++;
      $display("FAIL %s band%0d: valid=%b data=%h, required valid=1 data=%h", nm, i, band_rd_valid_oh, band_rd_data_od, exp);
    end
    cyc();
    checks++;
    if (band_rd_valid_oh !== 1'b0 || band_rd_data_od !== exp) begin
      errors++;
      $display("FAIL %s_hold band%0d: valid=%b data=%h, required valid=0 data=%h", nm, i, band_rd_valid_oh, band_rd_data_od, exp);
    end
  endtask

  task automatic wait_rdy(input string nm);
    int n = 0;
    while (band_rdy_oh !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (band_rdy_oh !== 1'b1) begin
      errors++;
      $display("FAIL %s_rdy: band_rdy_oh=%b after %0d cycles, required 1", nm, band_rdy_oh, n);
    end
    cyc();
  endtask

  task automatic test_reset;
    logic bad = 1'b0;
    rst_ih = 1'b1;
    cyc();
    cyc();
    rst_ih = 1'b0;
    repeat (20) begin
      cyc();
      if ({band_rd_valid_oh, band_rd_data_od, band_rdy_oh, busy_oh, ovr_oh} !== 36'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_idle: valid=%b data=%h rdy=%b busy=%b ovr=%b, required all 0", band_rd_valid_oh, band_rd_data_od, band_rdy_oh, busy_oh, ovr_oh);
    end
    for (int i = 0; i < 8; i++) read_band(i, 32'd0, "reset_read");
  endtask

  task automatic test_frame1;
    for (int i = 0; i < 16; i++) wr_bin(i, 32'd50);
    pulse_done();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      checks++;
      if (band_rdy_oh !== (k == 8)) begin
        errors++;
        $display("FAIL frame1_latency k=%0d: band_rdy_oh=%b, required %b", k, band_rdy_oh, (k == 8));
      end
      if (k == 1) begin
        checks++;
        if (busy_oh !== 1'b1) begin
          errors++;
          $display("FAIL frame1_busy: busy_oh=%b, required 1", busy_oh);
        end
      end
    end
    read_band(0, 32'd800, "frame1");
    for (int i = 1; i < 8; i++) read_band(i, 32'd0, "frame1");
  endtask

  task automatic test_decay;
    pulse_done();
    wait_rdy("frame2");
`ifdef FGYRUS_BAND_PEAK_HOLD_EN
    read_band(0, 32'd700, "frame2_decay");
`else
    read_band(0, 32'd0, "frame2_decay");
`endif
  endtask

  task automatic test_saturation;
    wr_bin(16, 32'hFFFF_FFF0);
    wr_bin(17, 32'h0000_0100);
    pulse_done();
    wait_rdy("sat");
    read_band(1, 32'hFFFF_FFFF, "sat");
  endtask

  task automatic test_same_cycle;
    fft_res_wr_addr_id = 7'd40;
    fft_res_wr_data_id = 32'd7;
    fft_res_wr_en_ih   = 1'b1;
    fgyrus_fft_done_ih = 1'b1;
    cyc();
    fgyrus_fft_done_ih = 1'b0;
    fft_res_wr_data_id = 32'd9;
    cyc();
    fft_res_wr_en_ih   = 1'b0;
    wait_rdy("same_a");
    read_band(2, 32'd7, "same_a");
    pulse_done();
    wait_rdy("same_b");
    read_band(2, 32'd9, "same_b");
  endtask

  task automatic test_overrun;
    int pulses = 0;
    pulse_done();
    cyc();
    cyc();
    pulse_done();
    repeat (20) begin
      if (band_rdy_oh === 1'b1) pulses++;
      cyc();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ovr_pulses: saw %0d band_rdy_oh pulses, required 1", pulses);
    end
    checks++;
    if (ovr_oh !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: ovr_oh=%b, required 1", ovr_oh);
    end
    ovr_clr_ih = 1'b1;
    cyc();
    ovr_clr_ih = 1'b0;
    checks++;
    if (ovr_oh !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr: ovr_oh=%b, required 0", ovr_oh);
    end
    pulse_done();
    cyc();
    fgyrus_fft_done_ih = 1'b1;
    ovr_clr_ih = 1'b1;
    cyc();
    fgyrus_fft_done_ih = 1'b0;
    ovr_clr_ih = 1'b0;
    checks++;
    if (ovr_oh !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins: ovr_oh=%b, required 1", ovr_oh);
    end
    repeat (12) cyc();
  endtask

  task automatic test_reset_mid_update;
    int pulses = 0;
    pulse_done();
    cyc();
    cyc();
    rst_ih = 1'b1;
    cyc();
    rst_ih = 1'b0;
    checks++;
    if (busy_oh !== 1'b0 || ovr_oh !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: busy_oh=%b ovr_oh=%b, required 0 0", busy_oh, ovr_oh);
    end
    repeat (12) begin
      if (band_rdy_oh === 1'b1) pulses++;
      cyc();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_mid_rdy: saw %0d band_rdy_oh pulses, required 0", pulses);
    end
    read_band(1, 32'd0, "rst_mid");
  endtask

  initial begin
    test_reset();
    test_frame1();
    test_decay();
    test_saturation();
    test_same_cycle();
    test_overrun();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
